rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / w_reg / w_data) of the decode stage between two writeback sources.
  - Source A: the single-cycle ALU/load writeback path.
  - Source B: a multicycle unit (mul/div).
- Round-robin arbitration with a valid/ready handshake. The output stage is registered.
- Keeps a 32-entry pending scoreboard of destinations owed by source B, so the hazard logic can stall dependent decodes.

---
 rtl/rf_write_arbiter.sv | 102 ++++++++++
 tb/tb_rf_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the single-cycle
// writeback path (A) and the multicycle unit (B), with a pending-destination scoreboard for B.
module rf_write_arbiter #(
    parameter int unsigned WORD    = 64,
    parameter int unsigned RADDR   = 5,
    parameter int unsigned LR_IDX  = 30,
    parameter int unsigned XZR_IDX = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [RADDR-1:0] a_reg,
    input  logic             a_link,
    input  logic [WORD-1:0]  a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [RADDR-1:0] b_reg,
    input  logic [WORD-1:0]  b_data,
    input  logic             b_issue,
    input  logic [RADDR-1:0] b_issue_reg,
    output logic             RegWrite,
    output logic [RADDR-1:0] w_reg,
    output logic [WORD-1:0]  w_data,
    output logic             w_src_b,
    output logic [31:0]      pend
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t            last;
    logic             grant_a;
    logic             grant_b;
    logic             a_xfer;
    logic             b_xfer;
    logic [RADDR-1:0] ea;
    logic [31:0]      set_vec;
    logic [31:0]      clr_vec;

    assign ea = a_link ? RADDR'(LR_IDX) : a_reg;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!stall) begin
            if (a_valid && b_valid) begin
                if (last == LAST_B) grant_a = 1'b1;
                else                grant_b = 1'b1;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a & ~rst;
    assign b_ready = grant_b & ~rst;
    assign a_xfer  = a_valid & a_ready;
    assign b_xfer  = b_valid & b_ready;

    // Set is applied after clear so a re-issued destination stays pending.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (b_issue && (b_issue_reg != RADDR'(XZR_IDX))) set_vec[b_issue_reg] = 1'b1;
        if (b_xfer) clr_vec[b_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite <= 1'b0;
            w_reg    <= '0;
            w_data   <= '0;
            w_src_b  <= 1'b0;
            last     <= LAST_B;
        end else if (a_xfer) begin
            RegWrite <= (ea != RADDR'(XZR_IDX));
            w_reg    <= ea;
            w_data   <= a_data;
            w_src_b  <= 1'b0;
            last     <= LAST_A;
        end else if (b_xfer) begin
            RegWrite <= (b_reg != RADDR'(XZR_IDX));
            w_reg    <= b_reg;
            w_data   <= b_data;
            w_src_b  <= 1'b1;
            last     <= LAST_B;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~clr_vec) | set_vec;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, round-robin ties, link/XZR handling,
// scoreboard set/clear, stall and asynchronous reset during a write.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic        a_link;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [63:0] b_data;
    logic        b_issue;
    logic [4:0]  b_issue_reg;
    logic        RegWrite;
    logic [4:0]  w_reg;
    logic [63:0] w_data;
    logic        w_src_b;
    logic [31:0] pend;

    int vectors = 0;
    int miscompares = 0;

    rf_write_arbiter #(.WORD(64), .RADDR(5), .LR_IDX(30), .XZR_IDX(31)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_link(a_link), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .b_issue(b_issue), .b_issue_reg(b_issue_reg),
        .RegWrite(RegWrite), .w_reg(w_reg), .w_data(w_data), .w_src_b(w_src_b), .pend(pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        stall = 0; a_valid = 0; a_reg = 0; a_link = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0; b_issue = 0; b_issue_reg = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        a_valid = 1; a_reg = 5; a_data = 64'h11;
        #2;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL rst_regwrite: got %0h want 0", RegWrite); end
        vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL rst_a_ready: got %0h want 0", a_ready); end
        vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL rst_pend: got %0h want 0", pend); end
        @(negedge clk);
        rst = 0;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL first_a_ready: got %0h want 1", a_ready); end
        vectors++; if (b_ready !== 1'b0) begin miscompares++; $display("FAIL first_b_ready: got %0h want 0", b_ready); end
        @(posedge clk); #1;
        vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL first_regwrite: got %0h want 1", RegWrite); end
        vectors++; if (w_reg !== 5'd5) begin miscompares++; $display("FAIL first_w_reg: got %0d want 5", w_reg); end
        vectors++; if (w_data !== 64'h11) begin miscompares++; $display("FAIL first_w_data: got %0h want 11", w_data); end
        vectors++; if (w_src_b !== 1'b0) begin miscompares++; $display("FAIL first_w_src_b: got %0h want 0", w_src_b); end
        @(negedge clk);
        a_valid = 0;
        @(posedge clk); #1;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL idle_regwrite: got %0h want 0", RegWrite); end
        vectors++; if (w_reg !== 5'd5) begin miscompares++; $display("FAIL idle_w_reg_hold: got %0d want 5", w_reg); end
    endtask

    task automatic test_tie_alternation();
        logic       exp_a;
        logic [4:0] exp_reg;
        apply_reset();
        a_valid = 1; a_reg = 1; a_data = 64'hA1;
        b_valid = 1; b_reg = 2; b_data = 64'hB2;
        for (int i = 0; i < 4; i++) begin
            exp_a   = (i % 2 == 0);
            exp_reg = exp_a ? 5'd1 : 5'd2;
            if (i != 0) @(negedge clk);
            #1;
            vectors++; if (a_ready !== exp_a) begin miscompares++; $display("FAIL tie_a_ready[%0d]: got %0h want %0h", i, a_ready, exp_a); end
            vectors++; if (b_ready !== !exp_a) begin miscompares++; $display("FAIL tie_b_ready[%0d]: got %0h want %0h", i, b_ready, !exp_a); end
            @(posedge clk); #1;
            vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL tie_regwrite[%0d]: got %0h want 1", i, RegWrite); end
            vectors++; if (w_reg !== exp_reg) begin miscompares++; $display("FAIL tie_w_reg[%0d]: got %0d want %0d", i, w_reg, exp_reg); end
            vectors++; if (w_src_b !== !exp_a) begin miscompares++; $display("FAIL tie_w_src_b[%0d]: got %0h want %0h", i, w_src_b, !exp_a); end
        end
        @(negedge clk);
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_link_xzr();
        a_valid = 1; a_link = 1; a_reg = 7; a_data = 64'h77;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL link_a_ready: got %0h want 1", a_ready); end
        @(posedge clk); #1;
        vectors++; if (w_reg !== 5'd30) begin miscompares++; $display("FAIL link_w_reg: got %0d want 30", w_reg); end
        vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL link_regwrite: got %0h want 1", RegWrite); end
        @(negedge clk);
        a_link = 0; a_reg = 31; a_data = 64'h99;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL xzr_a_ready: got %0h want 1", a_ready); end
        @(posedge clk); #1;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL xzr_regwrite: got %0h want 0", RegWrite); end
        vectors++; if (w_reg !== 5'd31) begin miscompares++; $display("FAIL xzr_w_reg: got %0d want 31", w_reg); end
        vectors++; if (w_data !== 64'h99) begin miscompares++; $display("FAIL xzr_w_data: got %0h want 99", w_data); end
        @(negedge clk);
        a_valid = 0;
    endtask

    task automatic test_scoreboard();
        b_issue = 1; b_issue_reg = 9;
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h200) begin miscompares++; $display("FAIL sb_set9: got %0h want 200", pend); end
        @(negedge clk);
        b_issue = 0; b_valid = 1; b_reg = 9; b_data = 64'h1234;
        #1;
        vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL sb_b_ready: got %0h want 1", b_ready); end
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL sb_clr9: got %0h want 0", pend); end
        vectors++; if (w_src_b !== 1'b1) begin miscompares++; $display("FAIL sb_w_src_b: got %0h want 1", w_src_b); end
        vectors++; if (w_data !== 64'h1234) begin miscompares++; $display("FAIL sb_w_data: got %0h want 1234", w_data); end
        @(negedge clk);
        b_valid = 0; b_issue = 1; b_issue_reg = 4;
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h10) begin miscompares++; $display("FAIL sb_set4: got %0h want 10", pend); end
        @(negedge clk);
        b_valid = 1; b_reg = 4;
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h10) begin miscompares++; $display("FAIL sb_set_wins: got %0h want 10", pend); end
        @(negedge clk);
        b_valid = 0; b_issue_reg = 31;
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h10) begin miscompares++; $display("FAIL sb_xzr_ignored: got %0h want 10", pend); end
        @(negedge clk);
        b_issue = 0; b_valid = 1; b_reg = 4;
        @(posedge clk); #1;
        vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL sb_clr4: got %0h want 0", pend); end
        @(negedge clk);
        b_valid = 0;
    endtask

    task automatic test_stall();
        // Last grant was B, so A wins the first tie after the stall.
        stall = 1;
        a_valid = 1; a_reg = 3; a_data = 64'h33;
        b_valid = 1; b_reg = 6; b_data = 64'h66;
        b_issue = 1; b_issue_reg = 12;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {a_ready, b_ready}); end
            @(posedge clk); #1;
            vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL stall_regwrite[%0d]: got %0h want 0", i, RegWrite); end
            vectors++; if (pend !== 32'h1000) begin miscompares++; $display("FAIL stall_pend[%0d]: got %0h want 1000", i, pend); end
            b_issue = 0;
        end
        @(negedge clk);
        stall = 0;
        #1;
        vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL unstall_first: got %b want 10", {a_ready, b_ready}); end
        @(posedge clk); #1;
        vectors++; if (w_reg !== 5'd3) begin miscompares++; $display("FAIL unstall_w_reg_a: got %0d want 3", w_reg); end
        @(negedge clk);
        a_valid = 0;
        #1;
        vectors++; if ({a_ready, b_ready} !== 2'b01) begin miscompares++; $display("FAIL unstall_second: got %b want 01", {a_ready, b_ready}); end
        @(posedge clk); #1;
        vectors++; if (w_reg !== 5'd6 || w_src_b !== 1'b1) begin miscompares++; $display("FAIL unstall_w_b: got reg %0d src %0h want reg 6 src 1", w_reg, w_src_b); end
        vectors++; if (pend !== 32'h1000) begin miscompares++; $display("FAIL unstall_pend: got %0h want 1000", pend); end
        @(negedge clk);
        b_valid = 0;
    endtask

    task automatic test_async_reset();
        a_valid = 1; a_reg = 8; a_data = 64'h88;
        @(posedge clk); #1;
        vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL pre_rst_regwrite: got %0h want 1", RegWrite); end
        #2;
        rst = 1;
        #1;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL async_regwrite: got %0h want 0", RegWrite); end
        vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL async_pend: got %0h want 0", pend); end
        vectors++; if (w_reg !== 5'd0) begin miscompares++; $display("FAIL async_w_reg: got %0d want 0", w_reg); end
        vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL async_a_ready: got %0h want 0", a_ready); end
        @(negedge clk);
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_link_xzr();
        test_scoreboard();
        test_stall();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
